// File: rtl/core_pkg.sv
// Core-wide constants and types shared by the memory arbiter and its FIFO.
package core_pkg;

  localparam int Xlen = 32;

  // Requester ids on the shared memory port
  localparam int   ArbPorts = 2;
  localparam logic ArbInst  = 1'b0;
  localparam logic ArbData  = 1'b1;

  typedef enum logic {
    ArbIdle,
    ArbLocked
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_owner_fifo.sv
// In-order record of which requester owns each accepted, unanswered request.
module owner_fifo #(
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       push_id_i,
  input  logic                       pop_i,
  output logic                       head_id_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [Depth-1:0] mem_q;
  logic do_push, do_pop;

  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_id_o = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push and pop in one cycle leave the count unchanged
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset drops every outstanding owner record
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Owner storage; contents are meaningless while the slot is unoccupied
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one downstream memory port between instruction fetch (port 0) and
// the LSU (port 1) with a locked round-robin grant; responses return in order.
module mem_arbiter #(
  parameter int Xlen           = core_pkg::Xlen,
  parameter int MaskBits       = Xlen / 8,
  parameter int MaxOutstanding = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [2*Xlen-1:0]     req_addr_i,
  input  logic [2*Xlen-1:0]     req_wdata_i,
  input  logic [2*MaskBits-1:0] req_wmask_i,
  output logic [Xlen-1:0]       rsp_rdata_o,
  output logic [1:0]            rsp_rvalid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_valid_o,
  output logic [Xlen-1:0]       mem_addr_o,
  output logic [Xlen-1:0]       mem_wdata_o,
  output logic [MaskBits-1:0]   mem_wmask_o,
  input  logic [Xlen-1:0]       mem_rdata_i,
  input  logic                  mem_rvalid_i
);

  import core_pkg::*;

  localparam int CntW = $clog2(MaxOutstanding) + 1;

  arb_state_e      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            lock_id_q, lock_id_d;
  logic            grant;
  logic            mem_valid;
  logic            accept;
  logic            pop;
  logic            fifo_full, fifo_empty, fifo_head;
  logic [CntW-1:0] fifo_count;

  // Grant selection and FSM next state; the grant is combinational so a ready
  // downstream accepts in the same cycle the request appears
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_id_d    = lock_id_q;
    grant        = lock_id_q;
    mem_valid    = 1'b0;
    case (state_q)
      ArbIdle: begin
        // Full is judged on the registered count, so a same-cycle pop does not free a slot
        if (!fifo_full && (req_valid_i != 2'b00)) begin
          mem_valid = 1'b1;
          if (req_valid_i == 2'b11) grant = ~last_grant_q;
          else                      grant = req_valid_i[1];
          if (mem_ready_i) begin
            last_grant_d = grant;
          end else begin
            lock_id_d = grant;
            state_d   = ArbLocked;
          end
        end
      end
      ArbLocked: begin
        // Hold the stalled request on the bus until the downstream takes it
        mem_valid = 1'b1;
        grant     = lock_id_q;
        if (mem_ready_i) begin
          last_grant_d = lock_id_q;
          state_d      = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
    if (rst_i) mem_valid = 1'b0;
  end

  // Downstream payload mux and response routing back to the recorded owner
  always_comb begin
    accept       = mem_valid && mem_ready_i;
    mem_valid_o  = mem_valid;
    req_ready_o  = 2'b00;
    if (accept) req_ready_o = grant ? 2'b10 : 2'b01;
    mem_addr_o   = grant ? req_addr_i[2*Xlen-1:Xlen]  : req_addr_i[Xlen-1:0];
    mem_wdata_o  = grant ? req_wdata_i[2*Xlen-1:Xlen] : req_wdata_i[Xlen-1:0];
    mem_wmask_o  = '0;
    if (mem_valid) mem_wmask_o = grant ? req_wmask_i[2*MaskBits-1:MaskBits]
                                       : req_wmask_i[MaskBits-1:0];
    pop          = mem_rvalid_i && !fifo_empty && !rst_i;
    rsp_rvalid_o = 2'b00;
    if (pop) rsp_rvalid_o = fifo_head ? 2'b10 : 2'b01;
    rsp_rdata_o  = mem_rdata_i;
  end

  // FSM state register; last_grant resets to data so inst wins the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ArbIdle;
      last_grant_q <= ArbData;
      lock_id_q    <= ArbInst;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_id_q    <= lock_id_d;
    end
  end

  owner_fifo #(
    .Depth(MaxOutstanding)
  ) u_owner_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (accept),
    .push_id_i (grant),
    .pop_i     (pop),
    .head_id_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  a_locked_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ArbLocked) |-> req_valid_i[lock_id_q]);

  a_rvalid_owned: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> !fifo_empty);

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_count <= CntW'(MaxOutstanding));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vectors plus an owner scoreboard for responses.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wmask_i;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_rvalid_o;
  logic        mem_ready_i;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .Xlen(32), .MaskBits(4), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_rvalid_o(rsp_rvalid_o),
    .mem_ready_i(mem_ready_i), .mem_valid_o(mem_valid_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic        mrdy;
    logic        mrv;
    logic [31:0] mrdata;
    logic [1:0]  e_rdy;
    logic        e_mv;
    logic [31:0] e_addr;
    logic [3:0]  e_wmask;
    logic [1:0]  e_rsp;
  } vec_t;

  localparam logic [31:0] InstAddr = 32'h100;
  localparam logic [31:0] DataAddr = 32'h200;
  localparam logic [31:0] DataWd   = 32'h12345678;

  vec_t vecs[$];
  logic sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] rv, input logic mrdy,
                     input logic mrv, input logic [31:0] mrdata, input logic [1:0] e_rdy,
                     input logic e_mv, input logic [31:0] e_addr, input logic [3:0] e_wmask,
                     input logic [1:0] e_rsp);
    vec_t v;
    v.rst = rst; v.rv = rv; v.mrdy = mrdy; v.mrv = mrv; v.mrdata = mrdata;
    v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_addr = e_addr; v.e_wmask = e_wmask; v.e_rsp = e_rsp;
    vecs.push_back(v);
  endtask

  // Drive one cycle, check mid-cycle, update the owner scoreboard, advance
  task automatic apply(input vec_t v, input string tag);
    logic exp_owner;
    rst_i = v.rst; req_valid_i = v.rv; mem_ready_i = v.mrdy;
    mem_rvalid_i = v.mrv; mem_rdata_i = v.mrdata;
    #4;
    chk({tag, " req_ready"}, 32'(req_ready_o), 32'(v.e_rdy));
    chk({tag, " mem_valid"}, 32'(mem_valid_o), 32'(v.e_mv));
    if (v.e_mv) begin
      chk({tag, " mem_addr"}, mem_addr_o, v.e_addr);
      chk({tag, " mem_wmask"}, 32'(mem_wmask_o), 32'(v.e_wmask));
      if (v.e_wmask != 4'h0) chk({tag, " mem_wdata"}, mem_wdata_o, DataWd);
    end
    if (v.rst) chk({tag, " reset wmask"}, 32'(mem_wmask_o), 32'h0);
    chk({tag, " rsp_rvalid"}, 32'(rsp_rvalid_o), 32'(v.e_rsp));
    if (rsp_rvalid_o != 2'b00) begin
      chk({tag, " rsp_rdata"}, rsp_rdata_o, v.mrdata);
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s scoreboard: response %b with no expected owner", tag, rsp_rvalid_o);
      end else begin
        exp_owner = sb.pop_front();
        chk({tag, " rsp_owner"}, 32'(rsp_rvalid_o), exp_owner ? 32'd2 : 32'd1);
      end
    end
    if (v.e_rdy != 2'b00) sb.push_back(v.e_rdy[1]);
    if (v.rst) sb.delete();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 2'b00; mem_ready_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    req_addr_i  = {DataAddr, InstAddr};
    req_wdata_i = {DataWd, 32'h0};
    req_wmask_i = {4'hF, 4'h0};
    @(posedge clk_i); #1;

    // Single requester: inst read, response two cycles later
    add(1, 2'b00, 0, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    add(0, 2'b01, 1, 0, 0,            2'b01, 1, InstAddr, 4'h0, 2'b00);
    add(0, 2'b00, 1, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    add(0, 2'b00, 1, 1, 32'hDEADBEEF, 2'b00, 0, 0,        4'h0, 2'b01);
    add(0, 2'b00, 1, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    // Contention and backpressure: alternate grants, stall at 4 outstanding
    add(1, 2'b00, 0, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    add(0, 2'b11, 1, 0, 0,            2'b01, 1, InstAddr, 4'h0, 2'b00);
    add(0, 2'b11, 1, 0, 0,            2'b10, 1, DataAddr, 4'hF, 2'b00);
    add(0, 2'b11, 1, 0, 0,            2'b01, 1, InstAddr, 4'h0, 2'b00);
    add(0, 2'b11, 1, 0, 0,            2'b10, 1, DataAddr, 4'hF, 2'b00);
    add(0, 2'b11, 1, 1, 32'hA,        2'b00, 0, 0,        4'h0, 2'b01);
    add(0, 2'b11, 1, 0, 0,            2'b01, 1, InstAddr, 4'h0, 2'b00);
    add(0, 2'b00, 1, 1, 32'h1,        2'b00, 0, 0,        4'h0, 2'b10);
    add(0, 2'b00, 1, 1, 32'h2,        2'b00, 0, 0,        4'h0, 2'b01);
    add(0, 2'b00, 1, 1, 32'h3,        2'b00, 0, 0,        4'h0, 2'b10);
    add(0, 2'b00, 1, 1, 32'h4,        2'b00, 0, 0,        4'h0, 2'b01);
    add(0, 2'b00, 1, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    // Lock: data stalled three cycles while inst waits; push+pop in one cycle
    add(1, 2'b00, 0, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    add(0, 2'b01, 1, 0, 0,            2'b01, 1, InstAddr, 4'h0, 2'b00);
    add(0, 2'b11, 0, 0, 0,            2'b00, 1, DataAddr, 4'hF, 2'b00);
    add(0, 2'b11, 0, 1, 32'h55,       2'b00, 1, DataAddr, 4'hF, 2'b01);
    add(0, 2'b11, 0, 0, 0,            2'b00, 1, DataAddr, 4'hF, 2'b00);
    add(0, 2'b11, 1, 0, 0,            2'b10, 1, DataAddr, 4'hF, 2'b00);
    add(0, 2'b11, 1, 1, 32'h66,       2'b01, 1, InstAddr, 4'h0, 2'b10);
    add(0, 2'b00, 1, 1, 32'h77,       2'b00, 0, 0,        4'h0, 2'b01);
    add(0, 2'b00, 1, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    // Ordering: inst, data, data answered A, B, C
    add(1, 2'b00, 0, 0, 0,            2'b00, 0, 0,        4'h0, 2'b00);
    add(0, 2'b01, 1, 0, 0,            2'b01, 1, InstAddr, 4'h0, 2'b00);
    add(0, 2'b10, 1, 0, 0,            2'b10, 1, DataAddr, 4'hF, 2'b00);
    add(0, 2'b10, 1, 0, 0,            2'b10, 1, DataAddr, 4'hF, 2'b00);
    add(0, 2'b00, 1, 1, 32'hA,        2'b00, 0, 0,        4'h0, 2'b01);
    add(0, 2'b00, 1, 1, 32'hB,        2'b00, 0, 0,        4'h0, 2'b10);
    add(0, 2'b00, 1, 1, 32'hC,        2'b00, 0, 0,        4'h0, 2'b10);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // Reset while Locked with two outstanding requests
    rst_i = 1'b1; req_valid_i = 2'b00; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_valid_i = 2'b01; mem_ready_i = 1'b1;
    #4 chk("mid0 req_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 2'b10;
    #4 chk("mid1 req_ready", 32'(req_ready_o), 32'd2);
    @(posedge clk_i); #1;
    req_valid_i = 2'b11; mem_ready_i = 1'b0;
    #4 chk("mid2 locked addr", mem_addr_o, InstAddr);
    chk("mid2 req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #4 chk("mid3 reset mem_valid", 32'(mem_valid_o), 32'd0);
    chk("mid3 reset req_ready", 32'(req_ready_o), 32'd0);
    chk("mid3 reset wmask", 32'(mem_wmask_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_valid_i = 2'b00;
    #4 chk("mid4 idle after reset", 32'(mem_valid_o), 32'd0);
    @(posedge clk_i); #1;
    sb.delete();
    // Records were dropped: four fresh acceptances fit, tie goes to inst first
    apply('{0, 2'b11, 1, 0, 32'h0, 2'b01, 1, InstAddr, 4'h0, 2'b00}, "post0");
    apply('{0, 2'b11, 1, 0, 32'h0, 2'b10, 1, DataAddr, 4'hF, 2'b00}, "post1");
    apply('{0, 2'b11, 1, 0, 32'h0, 2'b01, 1, InstAddr, 4'h0, 2'b00}, "post2");
    apply('{0, 2'b11, 1, 0, 32'h0, 2'b10, 1, DataAddr, 4'hF, 2'b00}, "post3");
    apply('{0, 2'b11, 1, 0, 32'h0, 2'b00, 0, 32'h0,    4'h0, 2'b00}, "post4");
    apply('{0, 2'b00, 1, 1, 32'h91, 2'b00, 0, 32'h0,   4'h0, 2'b01}, "post5");
    apply('{0, 2'b00, 1, 1, 32'h92, 2'b00, 0, 32'h0,   4'h0, 2'b10}, "post6");
    apply('{0, 2'b00, 1, 1, 32'h93, 2'b00, 0, 32'h0,   4'h0, 2'b01}, "post7");
    apply('{0, 2'b00, 1, 1, 32'h94, 2'b00, 0, 32'h0,   4'h0, 2'b10}, "post8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 100000);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
